// File: rtl/noc_stream_tx.sv
// NoC stream transmitter: buffers words from the global buffer in a small FIFO
// and streams a burst of `len` words toward a PE over a valid/ready-style link.
module noc_stream_tx #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     start,
  input  logic [7:0]               len,
  output logic [DATA_W-1:0]        noc_data,
  output logic                     noc_enable,
  input  logic                     pe_ready,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [7:0]          to_load_q, to_load_d;
  logic [DATA_W-1:0]   noc_data_q, noc_data_d;
  logic                noc_en_q, noc_en_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic full, empty, wr_en, rd_en, transfer, load;

  // FIFO status and the load/transfer handshake decode.
  always_comb begin
    full     = (count_q == CntW'(DEPTH));
    empty    = (count_q == '0);
    wr_en    = in_valid && !full;
    transfer = noc_en_q && pe_ready;
    // The output register refills whenever it is empty or being drained this edge.
    load     = (state_q == StSend) && (to_load_q != 8'd0) && !empty &&
               (!noc_en_q || transfer);
    rd_en    = load;
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Output register: load the FIFO head, or clear once the word is taken.
  always_comb begin
    noc_data_d = noc_data_q;
    noc_en_d   = noc_en_q;
    if (load) begin
      noc_data_d = mem_q[rd_ptr_q];
      noc_en_d   = 1'b1;
    end else if (transfer) begin
      noc_data_d = '0;
      noc_en_d   = 1'b0;
    end
  end

  // Burst FSM next-state and to_load countdown.
  always_comb begin
    state_d   = state_q;
    to_load_d = to_load_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          to_load_d = len;
          state_d   = (len == 8'd0) ? StDone : StSend;
        end
      end
      StSend: begin
        if (load) begin
          to_load_d = to_load_q - 8'd1;
        end
        // Finish only after the last loaded word has left the output register.
        if ((to_load_q == 8'd0) && !noc_en_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      to_load_q  <= 8'd0;
      noc_data_q <= '0;
      noc_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      to_load_q  <= to_load_d;
      noc_data_q <= noc_data_d;
      noc_en_q   <= noc_en_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready   = !full;
  assign noc_data   = noc_data_q;
  assign noc_enable = noc_en_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign fifo_count = count_q;

endmodule
